// File: rtl/shift_normalizer.sv
// shift_normalizer
//   Iterative normalizer: finds how far a word must be shifted so that its
//   MSB (direc=0, leading-zero count) or LSB (direc=1, trailing-zero count)
//   is 1, and produces the shifted word. Shifting norm by amt in the opposite
//   direction reproduces the captured data. One operation at a time, with a
//   start/done handshake.
//
//   Optional build macro SHIFT_NORM_NIBBLE_EN: when the 4 bits nearest the
//   target end are all zero, shift by 4 in one cycle. Results are identical;
//   only latency shrinks.
//
// Ports
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   start  : request pulse, accepted only when idle and not signalling done
//   data   : operand, captured on an accepted start
//   direc  : 0 = normalize left, 1 = normalize right; captured with data
//   busy   : high while the shift loop is running
//   done   : one-cycle pulse when norm/amt/zero are valid
//   norm   : normalized data
//   amt    : number of bit positions shifted
//   zero   : captured data was all zeros
module shift_normalizer #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic             direc,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] norm,
  output logic [AMT_W-1:0] amt,
  output logic             zero
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] work, work_nx;
  logic [AMT_W-1:0] cnt, cnt_nx;
  logic             dir_q, dir_nx;
  logic             accept;
  logic             tgt;

  // The done cycle is already IDLE, but a start there must still be ignored.
  assign accept = (state == IDLE) && start && !done;
  assign tgt    = dir_q ? work[0] : work[WIDTH-1];
  assign busy   = (state == SHIFT);

`ifdef SHIFT_NORM_NIBBLE_EN
  logic nib_zero;
  assign nib_zero = dir_q ? (work[3:0] == 4'b0) : (work[WIDTH-1 -: 4] == 4'b0);
`endif

  always_comb begin
    state_nx = state;
    work_nx  = work;
    cnt_nx   = cnt;
    dir_nx   = dir_q;
    case (state)
      IDLE: begin
        if (accept) begin
          work_nx  = data;
          dir_nx   = direc;
          cnt_nx   = '0;
          state_nx = (data == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (tgt) begin
          state_nx = DONE;
        end else begin
`ifdef SHIFT_NORM_NIBBLE_EN
          // Nonzero work always keeps cnt+4 within WIDTH-1 here.
          if (nib_zero) begin
            work_nx = dir_q ? (work >> 4) : (work << 4);
            cnt_nx  = cnt + AMT_W'(4);
          end else begin
            work_nx = dir_q ? (work >> 1) : (work << 1);
            cnt_nx  = cnt + AMT_W'(1);
          end
`else
          work_nx = dir_q ? (work >> 1) : (work << 1);
          cnt_nx  = cnt + AMT_W'(1);
`endif
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Control and visible results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      done  <= 1'b0;
      norm  <= '0;
      amt   <= '0;
      zero  <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= (state == DONE);
      if (state == DONE) begin
        norm <= work;
        amt  <= cnt;
      end
      if (accept) begin
        zero <= (data == '0);
      end
    end
  end

  // Work datapath; always loaded on an accepted start before it is used
  always_ff @(posedge clk) begin
    work  <= work_nx;
    cnt   <= cnt_nx;
    dir_q <= dir_nx;
  end

endmodule

// File: tb/tb_shift_normalizer.sv
// tb_shift_normalizer
//   Randomized and directed stimulus for shift_normalizer, checked every
//   cycle against a behavioural model (zero counting with plain arithmetic).
module tb_shift_normalizer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] data;
  logic         direc;
  logic         busy;
  logic         done;
  logic [W-1:0] norm;
  logic [4:0]   amt;
  logic         zero;

  shift_normalizer #(.WIDTH(W), .AMT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .data  (data),
    .direc (direc),
    .busy  (busy),
    .done  (done),
    .norm  (norm),
    .amt   (amt),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;

  // expectation of the operation in flight
  logic         pend = 1'b0;
  int           e0;
  int           exp_lat;
  logic [W-1:0] exp_norm;
  logic [4:0]   exp_amt;
  logic         exp_zero;
  logic [W-1:0] cap_data;
  logic         cap_dir;
  int           last_lat;
  int           busy_cnt;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic void model(input logic [W-1:0] d, input logic dir,
                                output logic [W-1:0] n, output logic [4:0] a,
                                output logic z, output int lat);
    int k;
    k = 0;
    z = (d == '0);
    if (z) begin
      n   = '0;
      a   = '0;
      lat = 1;
      return;
    end
    while (dir ? !d[k] : !d[W-1-k]) k++;
    n = dir ? (d >> k) : (d << k);
    a = k[4:0];
`ifdef SHIFT_NORM_NIBBLE_EN
    lat = k / 4 + k % 4 + 2;
`else
    lat = k + 2;
`endif
  endfunction

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (rst_n) begin
      logic eb;
      eb = pend && !exp_zero && (cyc >= e0) && (cyc <= e0 + exp_lat - 2);
      chk("busy", {31'b0, busy}, {31'b0, eb});
      if (busy) busy_cnt++;
      if (pend && cyc == e0 + exp_lat) begin
        chk("done", {31'b0, done}, 32'd1);
        chk("norm", norm, exp_norm);
        chk("amt", {27'b0, amt}, {27'b0, exp_amt});
        chk("zero", {31'b0, zero}, {31'b0, exp_zero});
        chk("roundtrip", cap_dir ? (norm << amt) : (norm >> amt), cap_data);
        last_lat = cyc - e0;
        pend = 1'b0;
      end else begin
        chk("no_done", {31'b0, done}, 32'd0);
      end
    end
  end

  task automatic launch(input logic [W-1:0] d, input logic dir);
    @(negedge clk);
    data  = d;
    direc = dir;
    start = 1'b1;
    @(posedge clk);
    #1;
    cap_data = d;
    cap_dir  = dir;
    model(d, dir, exp_norm, exp_amt, exp_zero, exp_lat);
    e0       = cyc;
    busy_cnt = 0;
    pend     = 1'b1;
  endtask

  // inj > 0: one stray start with all-ones data in loop iteration inj
  // inj < 0: random stray starts and input noise while the op runs
  task automatic run_op(input logic [W-1:0] d, input logic dir, input int inj);
    launch(d, dir);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (!pend) break;
      if (inj > 0 && i == inj) begin
        start = 1'b1;
        data  = 32'hFFFF_FFFF;
      end else if (inj < 0) begin
        start = ($urandom_range(0, 3) == 0);
        data  = $urandom;
        direc = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (pend) begin
      chk("timeout", 32'd1, 32'd0);
      pend = 1'b0;
    end
  endtask

  initial begin
    logic [W-1:0] rd;
    rst_n = 1'b0;
    start = 1'b0;
    data  = '0;
    direc = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_norm", norm, 32'd0);
    chk("rst_amt", {27'b0, amt}, 32'd0);
    chk("rst_zero", {31'b0, zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(32'h0000_0002, 1'b0, 0);
    chk("t1_norm", norm, 32'h8000_0000);
    chk("t1_amt", {27'b0, amt}, 32'd30);
`ifdef SHIFT_NORM_NIBBLE_EN
    chk("t1_lat_le12", {31'b0, (last_lat <= 12)}, 32'd1);
`else
    chk("t1_lat", last_lat, 32'd32);
    chk("t1_busy_cycles", busy_cnt, 32'd31);
`endif

    run_op(32'h0000_002F, 1'b1, 0);
    chk("t2_norm", norm, 32'h0000_002F);
    chk("t2_amt", {27'b0, amt}, 32'd0);
    chk("t2_lat", last_lat, 32'd2);

    run_op(32'h00A0_0000, 1'b1, 0);
    chk("t3_norm", norm, 32'h0000_0005);
    chk("t3_amt", {27'b0, amt}, 32'd21);
    chk("t3_back", norm << amt, 32'h00A0_0000);

    for (int dv = 0; dv < 2; dv++) begin
      run_op(32'h0, 1'(dv), 0);
      chk("t4_zero", {31'b0, zero}, 32'd1);
      chk("t4_norm", norm, 32'd0);
      chk("t4_amt", {27'b0, amt}, 32'd0);
      chk("t4_lat", last_lat, 32'd1);
      chk("t4_busy_cycles", busy_cnt, 32'd0);
    end

    run_op(32'h0000_0001, 1'b0, 3);
    chk("t5_amt", {27'b0, amt}, 32'd31);
    chk("t5_norm", norm, 32'h8000_0000);
    chk("t5_zero", {31'b0, zero}, 32'd0);

    // start during the done cycle must be ignored
    run_op(32'h0000_0100, 1'b0, 0);
    start = 1'b1;
    data  = 32'h0000_0010;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_busy", {31'b0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("b2b_norm", norm, 32'h8000_0000);

    // asynchronous abort mid-shift
    launch(32'h0000_0001, 1'b0);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    pend  = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_norm", norm, 32'd0);
    chk("abort_amt", {27'b0, amt}, 32'd0);
    chk("abort_zero", {31'b0, zero}, 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    run_op(32'h4000_0000, 1'b0, 0);
    chk("t6_amt", {27'b0, amt}, 32'd1);
    chk("t6_norm", norm, 32'h8000_0000);

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0:       rd = $urandom >> $urandom_range(0, 31);
        1:       rd = $urandom << $urandom_range(0, 31);
        2:       rd = (n % 10 == 0) ? 32'h0 : (32'h1 << $urandom_range(0, 31));
        default: rd = $urandom;
      endcase
      run_op(rd, 1'($urandom_range(0, 1)), -1);
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
